// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Picks one register-file write per cycle from three sources:
//   - ALU write-back, taken directly when granted,
//   - load returns, buffered in a small in-order FIFO,
//   - debug writes, lowest priority. A debug write that waits too long is
//     promoted above everything else.
// The chosen write appears on the registered rf_* outputs one cycle after
// the grant. Writes to x0 complete their handshake but never assert rf_we.
// A per-register bitmap, pending, marks registers with a load in flight.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   alu_valid/rd/data, alu_ready ALU write-back request and grant
//   lsu_valid/rd/data, lsu_ready load-return request; ready = FIFO has room
//   dbg_valid/rd/data, dbg_ready debug write request and grant
//   ld_issue, ld_issue_rd        a load has issued to ld_issue_rd
//   pending                      outstanding-load bitmap (registered)
//   rf_we, rf_addr_rd, rf_data_rd registered register-file write port
//
// Handshake: a transfer happens on a source in every cycle where its valid
// and ready are both high. alu_ready and dbg_ready are combinational grants
// and are low whenever their valid is low. lsu_ready only reflects FIFO
// space. All readies are low while reset is high.
module regfile_wb_arbiter #(
    parameter int DBG_AGE_LIMIT  = 8,
    parameter int LSU_FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    input  logic        dbg_valid,
    input  logic [4:0]  dbg_rd,
    input  logic [31:0] dbg_data,
    output logic        dbg_ready,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    output logic [31:0] pending,
    output logic        rf_we,
    output logic [4:0]  rf_addr_rd,
    output logic [31:0] rf_data_rd
);

    localparam int AGE_W = $clog2(DBG_AGE_LIMIT + 1);
    localparam int CNT_W = $clog2(LSU_FIFO_DEPTH + 1);
    localparam int PTR_W = (LSU_FIFO_DEPTH > 1) ? $clog2(LSU_FIFO_DEPTH) : 1;

    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(DBG_AGE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LSU_FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LSU_FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_DBG,
        SRC_FIFO,
        SRC_ALU
    } src_e;

    // Load-return FIFO.
    logic [4:0]       fifo_rd   [LSU_FIFO_DEPTH];
    logic [31:0]      fifo_data [LSU_FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [AGE_W-1:0] dbg_age;

    src_e        grant_src;
    logic        fifo_empty;
    logic        fifo_full;
    logic        enq;
    logic        deq;
    logic [4:0]  head_rd;
    logic [31:0] head_data;
    logic [4:0]  gnt_rd;
    logic [31:0] gnt_data;
    logic [31:0] pending_next;
    logic [AGE_W-1:0] dbg_age_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    assign head_rd    = fifo_rd[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    // Priority select. Grants are suppressed during reset so that any
    // handshake seen in a reset cycle is dropped.
    always_comb begin
        grant_src = SRC_NONE;
        if (!reset) begin
            if (dbg_valid && (dbg_age >= AGE_MAX)) begin
                grant_src = SRC_DBG;
            end else if (fifo_full) begin
                grant_src = SRC_FIFO;
            end else if (alu_valid) begin
                grant_src = SRC_ALU;
            end else if (!fifo_empty) begin
                grant_src = SRC_FIFO;
            end else if (dbg_valid) begin
                grant_src = SRC_DBG;
            end
        end
    end

    assign alu_ready = (grant_src == SRC_ALU);
    assign dbg_ready = (grant_src == SRC_DBG);
    assign lsu_ready = !reset && !fifo_full;

    assign enq = lsu_valid && lsu_ready;
    assign deq = (grant_src == SRC_FIFO);

    always_comb begin
        gnt_rd   = '0;
        gnt_data = '0;
        case (grant_src)
            SRC_DBG: begin
                gnt_rd   = dbg_rd;
                gnt_data = dbg_data;
            end
            SRC_FIFO: begin
                gnt_rd   = head_rd;
                gnt_data = head_data;
            end
            SRC_ALU: begin
                gnt_rd   = alu_rd;
                gnt_data = alu_data;
            end
            default: begin
                gnt_rd   = '0;
                gnt_data = '0;
            end
        endcase
    end

    // Age counts only while debug waits; any cycle without a debug request
    // or with a debug grant starts it over.
    always_comb begin
        dbg_age_next = '0;
        if (dbg_valid && !dbg_ready) begin
            dbg_age_next = (dbg_age < AGE_MAX) ? dbg_age + AGE_W'(1) : dbg_age;
        end
    end

    // Clear is applied before set so a same-cycle re-issue keeps the bit.
    always_comb begin
        pending_next = pending;
        if (deq) begin
            pending_next[head_rd] = 1'b0;
        end
        if (ld_issue) begin
            pending_next[ld_issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // FIFO storage needs no reset: count and pointers define which slots
    // are live.
    always_ff @(posedge clock) begin
        if (enq) begin
            fifo_rd[wr_ptr]   <= lsu_rd;
            fifo_data[wr_ptr] <= lsu_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            dbg_age <= '0;
            pending <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (deq) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            dbg_age <= dbg_age_next;
            pending <= pending_next;
        end
    end

    // Write port: address/data update on every grant (including x0) and
    // hold otherwise; the enable is only raised for a real register.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_addr_rd <= '0;
            rf_data_rd <= '0;
        end else if (grant_src != SRC_NONE) begin
            rf_we      <= (gnt_rd != 5'd0);
            rf_addr_rd <= gnt_rd;
            rf_data_rd <= gnt_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. Each cycle: advance past the
// clock edge, check registered outputs, drive the cycle's inputs, settle,
// then check the combinational readies.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        dbg_valid;
    logic [4:0]  dbg_rd;
    logic [31:0] dbg_data;
    logic        dbg_ready;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic [31:0] pending;
    logic        rf_we;
    logic [4:0]  rf_addr_rd;
    logic [31:0] rf_data_rd;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    regfile_wb_arbiter #(
        .DBG_AGE_LIMIT(8),
        .LSU_FIFO_DEPTH(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .alu_valid(alu_valid),
        .alu_rd(alu_rd),
        .alu_data(alu_data),
        .alu_ready(alu_ready),
        .lsu_valid(lsu_valid),
        .lsu_rd(lsu_rd),
        .lsu_data(lsu_data),
        .lsu_ready(lsu_ready),
        .dbg_valid(dbg_valid),
        .dbg_rd(dbg_rd),
        .dbg_data(dbg_data),
        .dbg_ready(dbg_ready),
        .ld_issue(ld_issue),
        .ld_issue_rd(ld_issue_rd),
        .pending(pending),
        .rf_we(rf_we),
        .rf_addr_rd(rf_addr_rd),
        .rf_data_rd(rf_data_rd)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        alu_rd      = 5'd0;
        alu_data    = 32'h0;
        lsu_valid   = 1'b0;
        lsu_rd      = 5'd0;
        lsu_data    = 32'h0;
        dbg_valid   = 1'b0;
        dbg_rd      = 5'd0;
        dbg_data    = 32'h0;
        ld_issue    = 1'b0;
        ld_issue_rd = 5'd0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = data;
    endtask

    task automatic drive_lsu(input logic [4:0] rd, input logic [31:0] data);
        lsu_valid = 1'b1;
        lsu_rd    = rd;
        lsu_data  = data;
    endtask

    task automatic drive_dbg(input logic [4:0] rd, input logic [31:0] data);
        dbg_valid = 1'b1;
        dbg_rd    = rd;
        dbg_data  = data;
    endtask

    task automatic chk_wb(input string tag, input logic [4:0] rd, input logic [31:0] data);
        chk({tag, "_we"}, 32'(rf_we), 32'd1);
        chk({tag, "_addr"}, 32'(rf_addr_rd), 32'(rd));
        chk({tag, "_data"}, rf_data_rd, data);
    endtask

    initial begin
        // Reset with every source active: nothing may be granted or stored.
        reset = 1'b1;
        idle();
        drive_alu(5'd9, 32'h99);
        drive_lsu(5'd9, 32'h98);
        drive_dbg(5'd9, 32'h97);
        ld_issue = 1'b1;
        ld_issue_rd = 5'd9;
        tick();
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_dbg_ready", 32'(dbg_ready), 32'd0);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_addr", 32'(rf_addr_rd), 32'd0);
        chk("rst_rf_data", rf_data_rd, 32'd0);
        chk("rst_pending", pending, 32'd0);
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("post_rst_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("post_rst_pending", pending, 32'd0);

        // ALU only.
        tick();
        chk("post_rst_rf_we", 32'(rf_we), 32'd0);
        drive_alu(5'd5, 32'hDEADBEEF);
        #1;
        chk("alu_ready", 32'(alu_ready), 32'd1);
        tick();
        chk_wb("alu_wb", 5'd5, 32'hDEADBEEF);
        idle();
        tick();
        chk("idle_rf_we", 32'(rf_we), 32'd0);
        chk("idle_hold_addr", 32'(rf_addr_rd), 32'd5);
        chk("idle_hold_data", rf_data_rd, 32'hDEADBEEF);

        // Contention: load accepted, then ALU beats a half-full FIFO.
        drive_lsu(5'd3, 32'h11);
        #1;
        chk("cont_lsu_ready", 32'(lsu_ready), 32'd1);
        tick();
        idle();
        drive_alu(5'd4, 32'h22);
        #1;
        chk("cont_alu_ready", 32'(alu_ready), 32'd1);
        chk("cont_no_pass_through", 32'(rf_we), 32'd0);
        tick();
        chk_wb("cont_wb_alu", 5'd4, 32'h22);
        idle();
        tick();
        chk_wb("cont_wb_load", 5'd3, 32'h11);

        // FIFO full against a continuously valid ALU.
        drive_lsu(5'd10, 32'hA0);
        drive_alu(5'd1, 32'h100);
        #1;
        chk("full_a_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        drive_lsu(5'd11, 32'hB0);
        alu_data = 32'h101;
        #1;
        chk("full_b_alu_ready", 32'(alu_ready), 32'd1);
        chk("full_b_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("full_b_rf_data", rf_data_rd, 32'h100);
        tick();
        drive_lsu(5'd12, 32'hC0);
        alu_data = 32'h102;
        #1;
        chk("full_c_lsu_ready", 32'(lsu_ready), 32'd0);
        chk("full_c_alu_ready", 32'(alu_ready), 32'd0);
        chk("full_c_rf_data", rf_data_rd, 32'h101);
        tick();
        lsu_valid = 1'b0;
        alu_data = 32'h103;
        #1;
        chk("full_d_alu_ready", 32'(alu_ready), 32'd1);
        chk("full_d_lsu_ready", 32'(lsu_ready), 32'd1);
        chk_wb("full_d_wb_head", 5'd10, 32'hA0);
        tick();
        alu_valid = 1'b0;
        drive_lsu(5'd13, 32'hD0);
        #1;
        chk_wb("full_e_wb_alu", 5'd1, 32'h103);
        tick();
        idle();
        chk_wb("full_f_wb_head", 5'd11, 32'hB0);
        tick();
        chk_wb("full_g_wb_enq_deq", 5'd13, 32'hD0);
        tick();
        chk("full_h_empty_rf_we", 32'(rf_we), 32'd0);

        // Debug aging under a continuously valid ALU.
        for (int k = 1; k <= 8; k++) begin
            drive_dbg(5'd20, 32'hDB);
            drive_alu(5'd2, 32'(k));
            #1;
            chk("age_dbg_wait", 32'(dbg_ready), 32'd0);
            tick();
        end
        chk_wb("age_alu_last", 5'd2, 32'd8);
        alu_data = 32'd9;
        #1;
        chk("age_dbg_ready", 32'(dbg_ready), 32'd1);
        chk("age_alu_held", 32'(alu_ready), 32'd0);
        tick();
        chk_wb("age_wb_dbg", 5'd20, 32'hDB);
        dbg_valid = 1'b0;
        alu_data = 32'd10;
        #1;
        chk("age_alu_resumes", 32'(alu_ready), 32'd1);
        tick();
        chk_wb("age_wb_alu", 5'd2, 32'd10);
        idle();
        drive_dbg(5'd21, 32'hD1);
        #1;
        chk("dbg_alone_ready", 32'(dbg_ready), 32'd1);
        tick();
        chk_wb("dbg_alone_wb", 5'd21, 32'hD1);
        idle();

        // Pending scoreboard.
        ld_issue = 1'b1;
        ld_issue_rd = 5'd7;
        tick();
        chk("pend_set", pending, 32'h80);
        idle();
        drive_lsu(5'd7, 32'h77);
        tick();
        chk("pend_before_grant", pending, 32'h80);
        idle();
        tick();
        chk("pend_cleared", pending, 32'h0);
        chk_wb("pend_wb", 5'd7, 32'h77);
        drive_lsu(5'd7, 32'h78);
        tick();
        idle();
        ld_issue = 1'b1;
        ld_issue_rd = 5'd7;
        tick();
        chk("pend_set_wins", pending, 32'h80);
        chk_wb("pend_wb2", 5'd7, 32'h78);
        ld_issue_rd = 5'd0;
        tick();
        chk("pend_rd0_ignored", pending, 32'h80);
        idle();
        drive_lsu(5'd7, 32'h79);
        tick();
        idle();
        tick();
        tick();
        chk("pend_cleared2", pending, 32'h0);

        // Reset mid-operation with two loads buffered.
        ld_issue = 1'b1;
        ld_issue_rd = 5'd3;
        tick();
        ld_issue_rd = 5'd7;
        drive_lsu(5'd3, 32'h33);
        drive_alu(5'd1, 32'h201);
        #1;
        chk("mid_alu_ready1", 32'(alu_ready), 32'd1);
        tick();
        ld_issue = 1'b0;
        drive_lsu(5'd7, 32'h37);
        alu_data = 32'h202;
        #1;
        chk("mid_alu_ready2", 32'(alu_ready), 32'd1);
        tick();
        chk("mid_pending", pending, 32'h88);
        reset = 1'b1;
        idle();
        #1;
        chk("mid_rst_lsu_ready", 32'(lsu_ready), 32'd0);
        tick();
        reset = 1'b0;
        chk("mid_rst_pending", pending, 32'h0);
        chk("mid_rst_rf_we", 32'(rf_we), 32'd0);
        chk("mid_rst_rf_addr", 32'(rf_addr_rd), 32'd0);
        chk("mid_rst_rf_data", rf_data_rd, 32'd0);
        #1;
        chk("mid_rst_lsu_ready_after", 32'(lsu_ready), 32'd1);
        tick();
        chk("mid_flushed_no_we", 32'(rf_we), 32'd0);
        drive_alu(5'd0, 32'h55);
        #1;
        chk("rd0_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        idle();
        chk("rd0_no_we", 32'(rf_we), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
